// File: rtl/cell_hist_acc.sv
// Per-cell HOG orientation histogram: sums (bin, magnitude) votes over PIX_N pixels.
// Optional macro CELL_HIST_SAT_EN makes each bin saturate instead of wrapping.
module cell_hist_acc #(
    parameter int unsigned MAG_W = 16,
    parameter int unsigned BIN_N = 9,
    parameter int unsigned BIN_W = 4,
    parameter int unsigned PIX_N = 64,
    parameter int unsigned ACC_W = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   i_valid,
    input  logic [BIN_W-1:0]       i_bin,
    input  logic [MAG_W-1:0]       i_mag,
    output logic [BIN_N*ACC_W-1:0] o_data,
    output logic                   o_valid
);

    localparam int unsigned CNT_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_N - 1);

    // Packed so that bin b sits at [b*ACC_W +: ACC_W], matching o_data directly.
    logic [BIN_N-1:0][ACC_W-1:0] acc_q, acc_d, acc_upd;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [BIN_N*ACC_W-1:0]      data_q, data_d;
    logic                        valid_q, valid_d;
    logic [ACC_W-1:0]            mag_ext, sel_acc, sum;

    assign mag_ext = ACC_W'(i_mag);

    // Out-of-range bins select nothing, so they never reach an accumulator.
    always_comb begin
        sel_acc = '0;
        for (int b = 0; b < int'(BIN_N); b++) begin
            if (i_bin == BIN_W'(b)) sel_acc = acc_q[b];
        end
    end

`ifdef CELL_HIST_SAT_EN
    logic [ACC_W:0] sum_wide;
    assign sum_wide = {1'b0, sel_acc} + {1'b0, mag_ext};
    assign sum      = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign sum = sel_acc + mag_ext;
`endif

    always_comb begin
        for (int b = 0; b < int'(BIN_N); b++) begin
            acc_upd[b] = (i_bin == BIN_W'(b)) ? sum : acc_q[b];
        end
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (i_valid) begin
            if (cnt_q == CNT_LAST) begin
                data_d  = acc_upd;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_upd;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_cell_hist_acc.sv
// Scoreboard bench for cell_hist_acc: a default instance plus an ACC_W=8 instance
// sharing stimulus; expected histograms are queued as votes are driven.
module tb_cell_hist_acc;

    localparam int MAG_W = 16;
    localparam int BIN_N = 9;
    localparam int BIN_W = 4;
    localparam int PIX_N = 64;
    localparam int ACC_W = 22;
    localparam int ACC_N = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   clear = 1'b0;
    logic                   i_valid = 1'b0;
    logic [BIN_W-1:0]       i_bin = '0;
    logic [MAG_W-1:0]       i_mag = '0;
    logic [BIN_N*ACC_W-1:0] w_data;
    logic                   w_valid;
    logic [BIN_N*ACC_N-1:0] n_data;
    logic                   n_valid;

    cell_hist_acc #(
        .MAG_W(MAG_W), .BIN_N(BIN_N), .BIN_W(BIN_W), .PIX_N(PIX_N), .ACC_W(ACC_W)
    ) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .i_valid(i_valid), .i_bin(i_bin),
        .i_mag(i_mag), .o_data(w_data), .o_valid(w_valid)
    );

    cell_hist_acc #(
        .MAG_W(MAG_W), .BIN_N(BIN_N), .BIN_W(BIN_W), .PIX_N(PIX_N), .ACC_W(ACC_N)
    ) dut_n (
        .clk(clk), .rst(rst), .clear(clear), .i_valid(i_valid), .i_bin(i_bin),
        .i_mag(i_mag), .o_data(n_data), .o_valid(n_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    longint                 sum_m [BIN_N];
    int                     cnt_m = 0;
    logic [BIN_N*ACC_W-1:0] exp_w_q [$];
    logic [BIN_N*ACC_N-1:0] exp_n_q [$];
    int                     exp_cyc_q [$];
    int                     pulse_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint fit(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef CELL_HIST_SAT_EN
        return (v > mx) ? mx : v;
`else
        return v & mx;
`endif
    endfunction

    task automatic model_reset();
        for (int b = 0; b < BIN_N; b++) sum_m[b] = 0;
        cnt_m = 0;
    endtask

    task automatic push_expect();
        logic [BIN_N*ACC_W-1:0] ew;
        logic [BIN_N*ACC_N-1:0] en;
        for (int b = 0; b < BIN_N; b++) begin
            ew[b*ACC_W +: ACC_W] = ACC_W'(fit(sum_m[b], ACC_W));
            en[b*ACC_N +: ACC_N] = ACC_N'(fit(sum_m[b], ACC_N));
        end
        exp_w_q.push_back(ew);
        exp_n_q.push_back(en);
        exp_cyc_q.push_back(cyc + 1);
    endtask

    // Drives one cycle of stimulus; the model follows what the DUT accepts on the next edge.
    task automatic vote(input int bin, input int mag, input bit v, input bit clr);
        @(negedge clk);
        i_valid = v;
        i_bin   = BIN_W'(bin);
        i_mag   = MAG_W'(mag);
        clear   = clr;
        if (clr) begin
            model_reset();
        end else if (v) begin
            if (bin < BIN_N) sum_m[bin] += longint'(mag);
            cnt_m++;
            if (cnt_m == PIX_N) begin
                push_expect();
                model_reset();
            end
        end
    endtask

    task automatic votes(input int n, input int bin, input int mag);
        for (int i = 0; i < n; i++) vote(bin, mag, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) vote(0, 0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst && w_valid) begin
            pulse_cyc.push_back(cyc);
            if (exp_w_q.size() == 0) begin
                check("spurious_pulse_w", 64'd1, 64'd0);
            end else begin
                logic [BIN_N*ACC_W-1:0] e;
                int c;
                e = exp_w_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("latency", 64'(cyc), 64'(c));
                for (int b = 0; b < BIN_N; b++)
                    check($sformatf("bin%0d", b), 64'(w_data[b*ACC_W +: ACC_W]),
                          64'(e[b*ACC_W +: ACC_W]));
            end
        end
        if (rst && n_valid) begin
            if (exp_n_q.size() == 0) begin
                check("spurious_pulse_n", 64'd1, 64'd0);
            end else begin
                logic [BIN_N*ACC_N-1:0] en;
                en = exp_n_q.pop_front();
                for (int b = 0; b < BIN_N; b++)
                    check($sformatf("narrow_bin%0d", b), 64'(n_data[b*ACC_N +: ACC_N]),
                          64'(en[b*ACC_N +: ACC_N]));
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check("rst_valid", 64'(w_valid), 64'd0);
        check("rst_data", 64'(w_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Single cell, bin 2 mag 10 -> 640.
        votes(64, 2, 10);
        idle(3);
        check("cell1_bin2", 64'(w_data[2*ACC_W +: ACC_W]), 64'd640);

        // Back-to-back cells, spacing 64 cycles.
        votes(64, 0, 1);
        votes(64, 8, 1000);
        idle(3);
        check("cellb_bin8", 64'(w_data[8*ACC_W +: ACC_W]), 64'd64000);
        if (pulse_cyc.size() >= 2)
            check("b2b_spacing", 64'(pulse_cyc[$] - pulse_cyc[$-1]), 64'd64);
        else
            check("b2b_pulses", 64'(pulse_cyc.size()), 64'd2);

        // Partial cell dropped by clear (with a simultaneous vote).
        votes(30, 5, 7);
        vote(5, 7, 1'b1, 1'b1);
        votes(63, 1, 3);
        idle(2);
        check("clear_no_early_pulse", 64'(exp_w_q.size()), 64'd0);
        votes(1, 1, 3);
        idle(3);
        check("clear_bin1", 64'(w_data[1*ACC_W +: ACC_W]), 64'd192);
        check("clear_bin5", 64'(w_data[5*ACC_W +: ACC_W]), 64'd0);

        // Gapped votes, alternating in-range and out-of-range bins.
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) vote(3, 4, 1'b1, 1'b0);
            else            vote(15, 999, 1'b1, 1'b0);
            vote(3, 500, 1'b0, 1'b0);
        end
        idle(3);
        check("gap_bin3", 64'(w_data[3*ACC_W +: ACC_W]), 64'd128);

        // Overflow in the narrow instance: wraps to 192 or saturates at 255.
        votes(64, 4, 255);
        idle(3);
`ifdef CELL_HIST_SAT_EN
        check("narrow_bin4_sat", 64'(n_data[4*ACC_N +: ACC_N]), 64'd255);
`else
        check("narrow_bin4_wrap", 64'(n_data[4*ACC_N +: ACC_N]), 64'd192);
`endif

        // Reset mid-cell discards the partial cell and clears outputs at once.
        votes(40, 6, 9);
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", 64'(w_valid), 64'd0);
        check("midrst_data", 64'(w_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        votes(64, 6, 2);
        idle(3);
        check("postrst_bin6", 64'(w_data[6*ACC_W +: ACC_W]), 64'd128);

        idle(2);
        check("pending_w", 64'(exp_w_q.size()), 64'd0);
        check("pending_n", 64'(exp_n_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
